// File: rtl/rob_wb_arbiter_pkg.sv
// rob_wb_arbiter_pkg: ROB constants shared by the writeback arbiter and the ROB FIFO-RAM
package rob_wb_arbiter_pkg;
    localparam int N_ENTRIES   = 8;
    localparam int PTR_WIDTH   = $clog2(N_ENTRIES);
    localparam int ENTRY_WIDTH = 32;
    localparam int N_WR_PORTS  = 2;
    localparam int N_REQ       = 4;
    localparam int CNT_WIDTH   = 16;

    typedef logic [PTR_WIDTH-1:0]   rob_idx_t;
    typedef logic [ENTRY_WIDTH-1:0] rob_data_t;

    // modulo add without relying on power-of-two wrap
    function automatic int wrap_add(int a, int b, int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction
endpackage

// File: rtl/rob_wb_arbiter_if.sv
// rob_wb_arbiter_if: writeback request bus and FIFO-RAM write-port bundle
interface rob_wb_arbiter_if #(
    parameter int N_REQ       = rob_wb_arbiter_pkg::N_REQ,
    parameter int N_WR_PORTS  = rob_wb_arbiter_pkg::N_WR_PORTS,
    parameter int PTR_WIDTH   = rob_wb_arbiter_pkg::PTR_WIDTH,
    parameter int ENTRY_WIDTH = rob_wb_arbiter_pkg::ENTRY_WIDTH
);
    logic [N_REQ-1:0]                        req_valid;
    logic [N_REQ-1:0][PTR_WIDTH-1:0]         req_addr;
    logic [N_REQ-1:0][ENTRY_WIDTH-1:0]       req_data;
    logic [N_REQ-1:0]                        req_ready;
    logic                                    flush;
    logic [N_WR_PORTS-1:0]                   wr_en;
    logic [N_WR_PORTS-1:0][PTR_WIDTH-1:0]    wr_addr;
    logic [N_WR_PORTS-1:0][ENTRY_WIDTH-1:0]  wr_data;

    modport master (
        output req_valid, req_addr, req_data, flush,
        input  req_ready, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  req_valid, req_addr, req_data, flush,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rob_wb_arbiter_picker.sv
// rob_wb_arbiter_picker: stateless round-robin scan granting up to N_WR_PORTS requesters
module rob_wb_arbiter_picker #(
    parameter int N_REQ      = rob_wb_arbiter_pkg::N_REQ,
    parameter int N_WR_PORTS = rob_wb_arbiter_pkg::N_WR_PORTS,
    parameter int IW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0]                 req_valid_i,
    input  logic [IW-1:0]                    rr_ptr_i,
    output logic [N_REQ-1:0]                 grant_o,
    output logic [N_WR_PORTS-1:0][IW-1:0]    port_idx_o,
    output logic [N_WR_PORTS-1:0]            port_vld_o
);
    import rob_wb_arbiter_pkg::*;

    always_comb begin
        int n;
        int idx;
        grant_o    = '0;
        port_idx_o = '0;
        port_vld_o = '0;
        n          = 0;
        idx        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = wrap_add(int'(rr_ptr_i), k, N_REQ);
            if (req_valid_i[idx] && n < N_WR_PORTS) begin
                grant_o[idx]   = 1'b1;
                port_idx_o[n]  = IW'(idx);
                port_vld_o[n]  = 1'b1;
                n              = n + 1;
            end
        end
    end
endmodule

// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: round-robin writeback arbiter feeding the ROB FIFO-RAM write ports
module rob_wb_arbiter #(
    parameter int N_REQ       = rob_wb_arbiter_pkg::N_REQ,
    parameter int N_WR_PORTS  = rob_wb_arbiter_pkg::N_WR_PORTS,
    parameter int N_ENTRIES   = rob_wb_arbiter_pkg::N_ENTRIES,
    parameter int PTR_WIDTH   = $clog2(N_ENTRIES),
    parameter int ENTRY_WIDTH = rob_wb_arbiter_pkg::ENTRY_WIDTH,
    parameter int CNT_WIDTH   = rob_wb_arbiter_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_aL,
    rob_wb_arbiter_if.slave      bus,
    output logic [CNT_WIDTH-1:0] congest_cnt_o
);
    import rob_wb_arbiter_pkg::*;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]                          rr_ptr_q, rr_ptr_d;
    logic [N_WR_PORTS-1:0]                  wr_en_q, wr_en_d;
    logic [N_WR_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [N_WR_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;
    logic [N_REQ-1:0]                       valid_eff, grant;
    logic [N_WR_PORTS-1:0][IW-1:0]          port_idx;
    logic [N_WR_PORTS-1:0]                  port_vld;
    logic                                   congested;

    // masking the requests on flush blocks grants and freezes rr_ptr in one place
    assign valid_eff = bus.flush ? '0 : bus.req_valid;
    assign congested = !bus.flush && ($countones(bus.req_valid) > N_WR_PORTS);

    rob_wb_arbiter_picker #(
        .N_REQ      (N_REQ),
        .N_WR_PORTS (N_WR_PORTS),
        .IW         (IW)
    ) u_picker (
        .req_valid_i (valid_eff),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .port_idx_o  (port_idx),
        .port_vld_o  (port_vld)
    );

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = port_vld;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        for (int p = 0; p < N_WR_PORTS; p++) begin
            if (port_vld[p]) begin
                rr_ptr_d     = IW'(wrap_add(int'(port_idx[p]), 1, N_REQ));
                wr_addr_d[p] = bus.req_addr[port_idx[p]];
                wr_data_d[p] = bus.req_data[port_idx[p]];
            end
        end
        cnt_d = (congested && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.wr_en     = wr_en_q & ~{N_WR_PORTS{bus.flush}};
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign congest_cnt_o = cnt_q;
endmodule
